// File: rtl/frame_buffer_if.sv
// AXI-Stream style bundle shared by the input and output sides of frame_buffer.
//   tdata  - beat data
//   tkeep  - byte enables, low-justified contiguous
//   tvalid - beat valid (source)
//   tlast  - last beat of a frame
//   tready - sink can accept the beat
// master: drives the payload and valid, receives ready. slave: the reverse.
interface frame_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_NUM   = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [BYTE_NUM-1:0]   tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_buffer.sv
// Store-and-forward frame buffer.
// Frames arriving on i_axis are written into a circular RAM. Each frame's byte
// count is checked against i_length (latched on the first beat). Good frames are
// committed; bad frames are rewound and never appear on the output. Each
// committed frame is replayed on m_axis after WAIT_CYCLES idle clocks.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_axis   - input stream (slave side)
//   i_length - declared byte length of the frame being received
//   m_axis   - output stream (master side), registered outputs
//
// Read FSM:
//   state  | meaning
//   S_IDLE | no committed frame waiting
//   S_WAIT | inter-frame gap, counting WAIT_CYCLES clocks
//   S_SEND | presenting beats of the frame at rd_ptr
module frame_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int BYTE_NUM    = 4,
    parameter int WAIT_CYCLES = 10,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_buffer_if.slave     i_axis,
    input  logic [31:0]       i_length,
    frame_buffer_if.master    m_axis
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int EW    = 1 + BYTE_NUM + DATA_WIDTH;
    localparam int GW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(WAIT_CYCLES - 1);

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    logic [EW-1:0] mem [DEPTH];

    ptr_t   wr_ptr;       // committed write pointer (= start of frame in progress)
    ptr_t   cur_ptr;      // next write location inside the current frame
    ptr_t   rd_ptr;
    cnt_t   occ;          // includes uncommitted beats
    cnt_t   frame_beats;  // beats written so far in the current frame
    cnt_t   frame_cnt;    // committed frames not yet fully sent
    logic [31:0] byte_cnt;
    logic [31:0] len_q;
    logic        in_frame;
    logic        err;

    state_t          state;
    logic [GW-1:0]   gap;
    logic [DATA_WIDTH-1:0] m_data;
    logic [BYTE_NUM-1:0]   m_keep;
    logic                  m_valid;
    logic                  m_last;

    logic        full, wr_fire, overrun, end_acc, end_ovr, commit, drop;
    logic        rd_fire, send_done;
    logic [31:0] kb, byte_total, len_eff;
    cnt_t        frame_cnt_next, occ_next;
    ptr_t        rd_ptr_inc;
    logic [EW-1:0] ent_cur, ent_nxt;

    assign full           = (occ == cnt_t'(DEPTH));
    assign i_axis.tready  = rst_n & ~full;
    assign wr_fire        = i_axis.tvalid & i_axis.tready;
    // Source kept driving while we were refusing beats: the frame is corrupt.
    assign overrun        = in_frame & i_axis.tvalid & ~i_axis.tready;

    always_comb begin
        kb = '0;
        for (int k = 0; k < BYTE_NUM; k++) kb = kb + 32'(i_axis.tkeep[k]);
    end

    assign byte_total = byte_cnt + kb;
    assign len_eff    = in_frame ? len_q : i_length;
    assign end_acc    = wr_fire & i_axis.tlast;
    // An overrun frame can never be completed once the RAM is full; treating its
    // refused tlast as the end of the frame releases the space and avoids deadlock.
    assign end_ovr    = overrun & i_axis.tlast;
    assign commit     = end_acc & (byte_total == len_eff) & ~err;
    assign drop       = (end_acc & ~commit) | end_ovr;

    assign rd_fire        = (state == S_SEND) & m_valid & m_axis.tready;
    assign send_done      = rd_fire & m_last;
    assign frame_cnt_next = frame_cnt + cnt_t'(commit) - cnt_t'(send_done);
    // On a drop the current (accepted) beat and all earlier beats of the frame
    // are released, which nets out to subtracting frame_beats.
    assign occ_next       = drop ? (occ - cnt_t'(rd_fire) - frame_beats)
                                 : (occ + cnt_t'(wr_fire) - cnt_t'(rd_fire));
    assign rd_ptr_inc     = rd_ptr + ptr_t'(1);
    assign ent_cur        = mem[rd_ptr];
    assign ent_nxt        = mem[rd_ptr_inc];

    assign m_axis.tdata  = m_data;
    assign m_axis.tkeep  = m_keep;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;

    always_ff @(posedge clk) begin
        if (wr_fire) mem[cur_ptr] <= {i_axis.tlast, i_axis.tkeep, i_axis.tdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            cur_ptr     <= '0;
            frame_beats <= '0;
            byte_cnt    <= '0;
            len_q       <= '0;
            in_frame    <= 1'b0;
            err         <= 1'b0;
        end else if (end_acc || end_ovr) begin
            in_frame    <= 1'b0;
            byte_cnt    <= '0;
            err         <= 1'b0;
            frame_beats <= '0;
            if (commit) begin
                wr_ptr  <= cur_ptr + ptr_t'(1);
                cur_ptr <= cur_ptr + ptr_t'(1);
            end else begin
                cur_ptr <= wr_ptr;
            end
        end else if (wr_fire) begin
            in_frame    <= 1'b1;
            if (!in_frame) len_q <= i_length;
            byte_cnt    <= byte_total;
            cur_ptr     <= cur_ptr + ptr_t'(1);
            frame_beats <= frame_beats + cnt_t'(1);
        end else if (overrun) begin
            err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ       <= '0;
            frame_cnt <= '0;
        end else begin
            occ       <= occ_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gap     <= '0;
            rd_ptr  <= '0;
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    gap <= '0;
                    if (frame_cnt != '0) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (gap == GAP_LAST) begin
                        state   <= S_SEND;
                        m_valid <= 1'b1;
                        m_last  <= ent_cur[EW-1];
                        m_keep  <= ent_cur[EW-2 -: BYTE_NUM];
                        m_data  <= ent_cur[DATA_WIDTH-1:0];
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                S_SEND: begin
                    if (rd_fire) begin
                        rd_ptr <= rd_ptr_inc;
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_keep  <= '0;
                            m_data  <= '0;
                            gap     <= '0;
                            state   <= (frame_cnt_next != '0) ? S_WAIT : S_IDLE;
                        end else begin
                            // Prefetch the next beat so a frame streams without bubbles.
                            m_last <= ent_nxt[EW-1];
                            m_keep <= ent_nxt[EW-2 -: BYTE_NUM];
                            m_data <= ent_nxt[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_buffer.sv
module tb_frame_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_length, i_length2;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_buffer_if #(.DATA_WIDTH(32), .BYTE_NUM(4)) i1 ();
    frame_buffer_if #(.DATA_WIDTH(32), .BYTE_NUM(4)) m1 ();
    frame_buffer_if #(.DATA_WIDTH(32), .BYTE_NUM(4)) i2 ();
    frame_buffer_if #(.DATA_WIDTH(32), .BYTE_NUM(4)) m2 ();

    frame_buffer #(.DATA_WIDTH(32), .BYTE_NUM(4), .WAIT_CYCLES(10), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .i_axis(i1), .i_length(i_length), .m_axis(m1));

    frame_buffer #(.DATA_WIDTH(32), .BYTE_NUM(4), .WAIT_CYCLES(10), .ADDR_WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .i_axis(i2), .i_length(i_length2), .m_axis(m2));

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct {
        int          nbeats;
        logic [3:0]  last_keep;
        logic [31:0] len;
        int          exp_beats;
        bit          toggle;
    } vec_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    seq = 0;
    int    stalls = 0;
    int    out_beats = 0;
    int    tlast_cyc = 0;
    int    first_valid_cyc = 0;
    int    last_end_cyc = 0;
    bit    last_end_ok = 0;
    bit    tog_mode = 0;

    // output monitor, sampled mid-cycle
    logic        pv = 0, pr = 0, pl = 0;
    logic [31:0] pd = 0;
    logic [3:0]  pk = 0;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            pv = 0;
            last_end_ok = 0;
        end else begin
            if (pv && !pr) begin
                checks++;
                if (!m1.tvalid || m1.tdata !== pd || m1.tkeep !== pk || m1.tlast !== pl) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b d=%h k=%h l=%0b, want v=1 d=%h k=%h l=%0b",
                             m1.tvalid, m1.tdata, m1.tkeep, m1.tlast, pd, pk, pl);
                end
            end
            if (!m1.tvalid) begin
                checks++;
                if (m1.tdata !== 32'h0 || m1.tkeep !== 4'h0 || m1.tlast !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_zero: got d=%h k=%h l=%0b, want all zero",
                             m1.tdata, m1.tkeep, m1.tlast);
                end
            end
            if (m1.tvalid && !pv) begin
                first_valid_cyc = cyc;
                if (last_end_ok) begin
                    checks++;
                    if (cyc - last_end_cyc - 1 < 10) begin
                        errors++;
                        $display("FAIL frame_gap: got %0d idle clocks, want >= 10",
                                 cyc - last_end_cyc - 1);
                    end
                end
            end
            if (m1.tvalid && m1.tready) begin
                out_beats++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got d=%h k=%h l=%0b, want no output",
                             m1.tdata, m1.tkeep, m1.tlast);
                end else begin
                    e = sb.pop_front();
                    if (m1.tdata !== e.d || m1.tkeep !== e.k || m1.tlast !== e.l) begin
                        errors++;
                        $display("FAIL out_beat: got d=%h k=%h l=%0b, want d=%h k=%h l=%0b",
                                 m1.tdata, m1.tkeep, m1.tlast, e.d, e.k, e.l);
                    end
                end
                if (m1.tlast) begin
                    last_end_cyc = cyc;
                    last_end_ok  = 1;
                end
            end
            pv = m1.tvalid; pr = m1.tready; pd = m1.tdata; pk = m1.tkeep; pl = m1.tlast;
        end
    end

    always @(posedge clk) begin
        #1;
        if (tog_mode) m1.tready = ~m1.tready;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat's edge.
    task automatic send_frame(input int n, input logic [3:0] lk, input logic [31:0] len,
                              input bit good);
        int w;
        for (int b = 0; b < n; b++) begin
            i1.tdata  = 32'(seq) ^ 32'h5A00_0000;
            i1.tkeep  = (b == n - 1) ? lk : 4'hF;
            i1.tlast  = (b == n - 1);
            i1.tvalid = 1'b1;
            i_length  = len;
            w = 0;
            while (!i1.tready && w < 2000) begin
                stalls++;
                @(posedge clk); #1;
                w++;
            end
            if (!i1.tready) begin
                errors++; checks++;
                $display("FAIL in_ready_timeout: got ready=0, want ready=1 within 2000 clocks");
            end
            if (good) sb.push_back({i1.tdata, i1.tkeep, i1.tlast});
            @(posedge clk); #1;
            seq++;
        end
        tlast_cyc = cyc;
        i1.tvalid = 1'b0;
        i1.tlast  = 1'b0;
        i1.tdata  = '0;
        i1.tkeep  = '0;
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((sb.size() != 0 || m1.tvalid) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_queue_empty", sb.size(), 0);
        repeat (30) @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];

    initial begin
        int    ob, w, acc;
        beat_t exp2[3];

        vecs[0] = '{250, 4'hF, 32'd1000, 250, 1'b0};
        vecs[1] = '{250, 4'h7, 32'd999,  250, 1'b0};
        vecs[2] = '{250, 4'h7, 32'd1000, 0,   1'b0};
        vecs[3] = '{250, 4'hF, 32'd1000, 250, 1'b1};
        vecs[4] = '{1,   4'h3, 32'd2,    1,   1'b0};
        vecs[5] = '{5,   4'h1, 32'd17,   5,   1'b0};
        vecs[6] = '{5,   4'hF, 32'd19,   0,   1'b0};

        rst_n = 1'b0;
        i_length = '0; i_length2 = '0;
        i1.tdata = '0; i1.tkeep = '0; i1.tvalid = 1'b0; i1.tlast = 1'b0;
        i2.tdata = '0; i2.tkeep = '0; i2.tvalid = 1'b0; i2.tlast = 1'b0;
        m1.tready = 1'b1;
        m2.tready = 1'b0;
        #1;
        check("reset_in_ready", 32'(i1.tready), 0);
        check("reset_out_valid", 32'(m1.tvalid), 0);
        check("reset_out_data", m1.tdata, 0);
        check("reset_out_keep_last", {27'd0, m1.tkeep, m1.tlast}, 0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_in_ready", 32'(i1.tready), 1);

        // latency from input tlast to first output beat on an idle buffer
        send_frame(250, 4'hF, 32'd1000, 1'b1);
        drain(3000);
        check("first_valid_latency", 32'(first_valid_cyc - tlast_cyc), 32'd11);

        // frame table
        for (int v = 0; v < 7; v++) begin
            ob = out_beats;
            tog_mode = vecs[v].toggle;
            send_frame(vecs[v].nbeats, vecs[v].last_keep, vecs[v].len, vecs[v].exp_beats != 0);
            drain(3000);
            tog_mode = 1'b0;
            m1.tready = 1'b1;
            check($sformatf("vec%0d_out_beats", v), 32'(out_beats - ob), 32'(vecs[v].exp_beats));
        end

        // back-to-back frames every 375 clocks
        stalls = 0;
        ob = out_beats;
        for (int f = 0; f < 4; f++) begin
            send_frame(250, 4'hF, 32'd1000, 1'b1);
            repeat (125) @(posedge clk);
            #1;
        end
        drain(3000);
        check("repeat_in_stalls", 32'(stalls), 0);
        check("repeat_out_beats", 32'(out_beats - ob), 32'd1000);

        // reset in the middle of sending a frame
        send_frame(250, 4'hF, 32'd1000, 1'b1);
        w = 0;
        while (!m1.tvalid && w < 100) begin @(posedge clk); #1; w++; end
        check("pre_reset_sending", 32'(m1.tvalid), 1);
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(m1.tvalid), 0);
        check("async_reset_in_ready", 32'(i1.tready), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_in_ready", 32'(i1.tready), 1);
        ob = out_beats;
        repeat (40) @(posedge clk);
        #1;
        check("after_reset_no_replay", 32'(out_beats - ob), 0);
        send_frame(8, 4'hF, 32'd32, 1'b1);
        drain(500);
        check("after_reset_frame", 32'(out_beats - ob), 32'd8);

        // small buffer: 20-beat frame with output blocked overruns 16 entries
        acc = 0;
        for (int b = 0; b < 20; b++) begin
            i2.tdata  = 32'hA000_0000 + 32'(b);
            i2.tkeep  = 4'hF;
            i2.tlast  = (b == 19);
            i2.tvalid = 1'b1;
            i_length2 = 32'd80;
            if (i2.tready) acc++;
            if (b == 16) check("small_ready_drop", 32'(i2.tready), 0);
            @(posedge clk); #1;
        end
        i2.tvalid = 1'b0; i2.tlast = 1'b0; i2.tdata = '0; i2.tkeep = '0;
        check("small_accepted", 32'(acc), 32'd16);
        check("small_ready_after_drop", 32'(i2.tready), 1);
        m2.tready = 1'b1;
        w = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (m2.tvalid) w++;
        end
        check("small_overrun_no_output", 32'(w), 0);
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            i2.tdata  = 32'hB000_0000 + 32'(b);
            i2.tkeep  = (b == 2) ? 4'h3 : 4'hF;
            i2.tlast  = (b == 2);
            i2.tvalid = 1'b1;
            i_length2 = 32'd10;
            exp2[b]   = {i2.tdata, i2.tkeep, i2.tlast};
            @(posedge clk); #1;
        end
        i2.tvalid = 1'b0; i2.tlast = 1'b0; i2.tdata = '0; i2.tkeep = '0;
        acc = 0;
        w = 0;
        while (acc < 3 && w < 200) begin
            @(negedge clk);
            w++;
            if (m2.tvalid && m2.tready) begin
                check($sformatf("small_out_beat%0d", acc),
                      {m2.tdata[27:0], m2.tkeep},
                      {exp2[acc].d[27:0], exp2[acc].k});
                check($sformatf("small_out_last%0d", acc), 32'(m2.tlast), 32'(exp2[acc].l));
                acc++;
            end
        end
        check("small_out_count", 32'(acc), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_buffer.md
Name:
frame_buffer

Overview:
- Store-and-forward AXI-Stream frame buffer between an upstream packet source and a downstream AXI-Stream consumer.
- Writes each incoming frame into an internal circular RAM.
- Checks the frame's byte count against the declared `i_length`; bad frames are discarded.
- Replays each complete good frame on the master port after an inter-frame gap of WAIT_CYCLES clocks.

Parameters:
- DATA_WIDTH, 32, stream data width in bits.
- BYTE_NUM, 4, bytes per beat (= DATA_WIDTH/8); width of tkeep.
- WAIT_CYCLES, 10, idle clocks inserted before every output frame (≥1).
- ADDR_WIDTH, 10, log2 of buffer depth in beats (default 1024 beats).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_axis_tdata  in  DATA_WIDTH  input beat data.
- i_axis_tkeep  in  BYTE_NUM  input byte enables, low-justified contiguous.
- i_axis_tvalid  in  1  input beat valid.
- i_axis_tlast  in  1  last beat of input frame.
- i_axis_tready  out  1  buffer can accept a beat.
- i_length  in  32  declared frame length in bytes; sampled on a frame's first accepted beat.
- m_axis_tdata  out  DATA_WIDTH  output beat data.
- m_axis_tkeep  out  BYTE_NUM  output byte enables.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  last beat of output frame.
- m_axis_tready  in  1  downstream accepts beat.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Pointers, frame counter, byte counter and state are cleared.
  - Outputs: i_axis_tready=0 while in reset, then 1; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0.
  - A frame in progress on either side is abandoned.
- Write side:
  - Beat accepted when i_axis_tvalid & i_axis_tready.
  - Each entry stores {tlast, tkeep, tdata}.
  - i_axis_tready = 1 when at least one free entry exists (free = 2^ADDR_WIDTH − occupied, occupied counts uncommitted beats too).
- Frame accounting:
  - On the first beat, i_length is latched and the frame start pointer is saved.
  - Byte counter accumulates popcount(tkeep) on every accepted beat.
  - Error flag sets if tvalid=1 while tready=0 mid-frame (source ignored backpressure).
- Commit on the accepted tlast beat:
  - Good frame = total bytes == latched length and no error → write pointer advanced; committed-frame counter +1 on that edge.
  - Otherwise the write pointer is rewound to the frame start (frame dropped, no output).
  - Byte counter and error flag clear for the next frame.
- Read FSM states: IDLE, WAIT, SEND.
  - IDLE → WAIT when committed-frame counter > 0; gap counter = 0.
  - WAIT: gap counter increments each clock; at WAIT_CYCLES−1 → SEND.
  - SEND: m_axis_tvalid=1 with the entry at the read pointer presented (tdata, tkeep, tlast exactly as stored); read pointer advances on m_axis_tvalid & m_axis_tready.
  - SEND, on the accepted beat with tlast=1: committed-frame counter −1, then → WAIT if another frame is committed, else IDLE.
- Latency: tlast accepted at edge T → first output beat valid after edge T+1+WAIT_CYCLES, if the buffer was idle.
- Backpressure: m_axis_tready=0 holds tdata/tkeep/tlast/tvalid stable; the gap is never inserted mid-frame.
- Simultaneous commit and send-complete in one clock: committed-frame counter stays unchanged (+1−1).
- Reads and writes proceed concurrently; the next frame may stream in while the previous one is output.
- Pointers wrap modulo 2^ADDR_WIDTH; full/empty distinguished by an occupancy counter.
- m_axis_tdata/tkeep/tlast = 0 whenever m_axis_tvalid=0.
- The RAM read path must keep the output registered or first-word-fall-through, with no bubbles inside a frame when m_axis_tready=1.

Test Plan:
- 250-beat frame, tkeep=0xF on all beats, i_length=1000, m_axis_tready=1 → 250 output beats, data identical, m_axis_tlast on beat 250, first valid 11 clocks after input tlast.
- Same frame repeated every 375 clocks (125-clock input gap) → every frame output intact; consecutive output frames separated by ≥10 idle clocks; no drops; i_axis_tready stays 1.
- Last beat tkeep=0x7, i_length=999 → frame output with final m_axis_tkeep=0x7; with i_length=1000 instead → no output beats, next good frame still output correctly.
- m_axis_tready toggling 1/0 each clock during SEND → output held stable while tready=0; all 250 beats delivered in order.
- ADDR_WIDTH=4 with a 20-beat frame and m_axis_tready=0 → i_axis_tready drops at 16 occupied entries; overrun beats set the error flag; frame dropped.
- rst_n pulsed low mid-SEND → m_axis_tvalid=0 immediately; buffer empty afterward; the next frame is output normally.
